// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control-word issue buffer.
// The entry layout mirrors the decoder output: opcode followed by its control word.
package ctrl_pkg;

   localparam int OP_W     = 7;
   localparam int CW_W     = 26;
   localparam int HOLD_BIT = 23;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [CW_W-1:0] cw;
   } ctrl_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      ISSUE = 2'd2
   } head_state_t;

endpackage

// File: rtl/ctrl_fifo_mem.sv
// Register-array storage for the issue buffer, with wrapping write/read pointers.
// Exposes the entry behind the current head so the next head can be registered on a pop.
module ctrl_fifo_mem
   import ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = OP_W + CW_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         wr_en,
   input  logic         rd_en,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] peek_data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign peek_data = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/ctrl_issue_buffer.sv
// Buffers decoded control words and issues them downstream over valid/ready.
// Multi-cycle entries sit at the head for HOLD_CYCLES cycles before becoming issuable.
module ctrl_issue_buffer
   import ctrl_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int OP_W        = ctrl_pkg::OP_W,
   parameter int CW_W        = ctrl_pkg::CW_W,
   parameter int HOLD_BIT    = ctrl_pkg::HOLD_BIT,
   parameter int HOLD_CYCLES = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [OP_W-1:0]            in_op,
   input  logic [CW_W-1:0]            in_cw,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OP_W-1:0]            out_op,
   output logic [CW_W-1:0]            out_cw,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int W     = OP_W + CW_W;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   head_state_t      state;
   head_state_t      state_nxt;
   logic [3:0]       hold_cnt;
   logic [3:0]       hold_nxt;
   logic             full;
   logic             push;
   logic             pop;
   logic             load_head;
   logic [W-1:0]     peek_data;
   logic [W-1:0]     head_data;

   // in_ready depends only on the registered count, never on out_ready
   assign full      = (count == FULL_CNT);
   assign in_ready  = ~full;
   assign out_valid = (state == ISSUE);
   assign occupancy = count;
   assign push      = in_valid & ~full & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
         endcase
      end
   end

   // With at most one stored entry, the next head is the entry being pushed now
   assign head_data = (count <= CNT_W'(1)) ? {in_op, in_cw} : peek_data;
   assign load_head = (push & (count == '0)) | (pop & (count_nxt != '0));

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      if (flush) begin
         state_nxt = IDLE;
         hold_nxt  = '0;
      end else if (load_head) begin
         if (head_data[HOLD_BIT]) begin
            state_nxt = HOLD;
            hold_nxt  = HOLD_LOAD;
         end else begin
            state_nxt = ISSUE;
            hold_nxt  = '0;
         end
      end else if (pop) begin
         state_nxt = IDLE;
      end else if (state == HOLD) begin
         if (hold_cnt == 4'd0) state_nxt = ISSUE;
         else                  hold_nxt  = hold_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         count    <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         count    <= count_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_op <= '0;
         out_cw <= '0;
      end else if (load_head) begin
         {out_op, out_cw} <= head_data;
      end
   end

   ctrl_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_mem (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flush),
      .wr_en     (push),
      .rd_en     (pop),
      .wr_data   ({in_op, in_cw}),
      .peek_data (peek_data)
   );

endmodule

// File: tb/tb_ctrl_issue_buffer.sv
// Directed bench for ctrl_issue_buffer: expected entries go into a scoreboard queue,
// and a negedge monitor compares every issued entry against it.
module tb_ctrl_issue_buffer;
   import ctrl_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [OP_W-1:0]     in_op;
   logic [CW_W-1:0]     in_cw;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [OP_W-1:0]     out_op;
   logic [CW_W-1:0]     out_cw;
   logic [2:0]          occupancy;

   ctrl_entry_t sb[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_issue_buffer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_cw     (in_cw),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_cw    (out_cw),
      .occupancy (occupancy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [OP_W-1:0] op, input logic [CW_W-1:0] cw, input bit accept);
      in_valid = 1'b1;
      in_op    = op;
      in_cw    = cw;
      if (accept) sb.push_back('{op: op, cw: cw});
   endtask

   // Monitor: every handshake pop must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         ctrl_entry_t e;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pop: got op=0x%0h cw=0x%0h, expected no issue", out_op, out_cw);
         end else begin
            e = sb.pop_front();
            if (out_op !== e.op || out_cw !== e.cw) begin
               errors++;
               $display("FAIL issue_order: got op=0x%0h cw=0x%0h, expected op=0x%0h cw=0x%0h",
                        out_op, out_cw, e.op, e.cw);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_cw = '0; flush = 1'b0; out_ready = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_out_op",    32'(out_op),    32'd0);
      chk("rst_out_cw",    32'(out_cw),    32'd0);
      #10 rst_n = 1'b1;
      step();

      // Single non-hold entry
      drive(7'h15, 26'h0000001, 1'b1);
      step();
      in_valid = 1'b0;
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_op",    32'(out_op),    32'h15);
      chk("t1_out_cw",    32'(out_cw),    32'h1);
      chk("t1_occ",       32'(occupancy), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t1_occ_drained", 32'(occupancy), 32'd0);
      chk("t1_valid_drained", 32'(out_valid), 32'd0);

      // Fill to full, fifth push dropped, then drain in order
      for (int i = 1; i <= 4; i++) begin
         drive(7'(i), 26'(i << 4), 1'b1);
         step();
      end
      chk("t2_in_ready_full", 32'(in_ready),  32'd0);
      chk("t2_occ_full",      32'(occupancy), 32'd4);
      drive(7'h05, 26'h50, 1'b0);
      step();
      in_valid = 1'b0;
      chk("t2_occ_after_drop", 32'(occupancy), 32'd4);
      chk("t2_head_unchanged", 32'(out_op),    32'h01);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("t2_drain_valid", 32'(out_valid), 32'd1);
         chk("t2_drain_op",    32'(out_op),    32'(i));
         step();
      end
      chk("t2_occ_empty", 32'(occupancy), 32'd0);
      chk("t2_valid_empty", 32'(out_valid), 32'd0);

      // Multi-cycle entry: three low cycles, one issue cycle
      drive(7'h2A, 26'h0800000, 1'b1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_hold_low", 32'(out_valid), 32'd0);
         step();
      end
      chk("t3_issue_high", 32'(out_valid), 32'd1);
      chk("t3_issue_op",   32'(out_op),    32'h2A);
      step();
      chk("t3_issue_once", 32'(out_valid), 32'd0);
      chk("t3_occ_empty",  32'(occupancy), 32'd0);

      // Streaming: one push and one pop per cycle
      for (int i = 0; i < 8; i++) begin
         drive(7'(8'h40 + i), 26'(12'h100 + i), 1'b1);
         step();
         chk("t4_occ_steady", 32'(occupancy), 32'd1);
         chk("t4_valid",      32'(out_valid), 32'd1);
         chk("t4_op",         32'(out_op),    32'(8'h40 + i));
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      chk("t4_occ_empty", 32'(occupancy), 32'd0);

      // Flush while the head is holding, with a concurrent push
      drive(7'h31, 26'h0800001, 1'b1);
      step();
      drive(7'h32, 26'h0000002, 1'b1);
      step();
      drive(7'h33, 26'h0000003, 1'b1);
      step();
      in_valid = 1'b0;
      chk("t5_occ_pre",   32'(occupancy), 32'd3);
      chk("t5_valid_pre", 32'(out_valid), 32'd0);
      flush = 1'b1;
      drive(7'h34, 26'h0000004, 1'b0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      chk("t5_occ_flush",   32'(occupancy), 32'd0);
      chk("t5_valid_flush", 32'(out_valid), 32'd0);
      chk("t5_ready_flush", 32'(in_ready),  32'd1);
      step();
      chk("t5_valid_stays", 32'(out_valid), 32'd0);
      drive(7'h35, 26'h0000005, 1'b1);
      step();
      in_valid = 1'b0;
      chk("t5_occ_new", 32'(occupancy), 32'd1);
      chk("t5_op_new",  32'(out_op),    32'h35);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t5_occ_final", 32'(occupancy), 32'd0);

      // Asynchronous reset in the middle of a hold
      drive(7'h51, 26'h0800000, 1'b1);
      step();
      drive(7'h52, 26'h0000006, 1'b1);
      step();
      in_valid = 1'b0;
      chk("t6_occ_pre",   32'(occupancy), 32'd2);
      chk("t6_valid_pre", 32'(out_valid), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      chk("t6_valid_async", 32'(out_valid), 32'd0);
      chk("t6_occ_async",   32'(occupancy), 32'd0);
      chk("t6_ready_async", 32'(in_ready),  32'd1);
      chk("t6_op_async",    32'(out_op),    32'd0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_idle_valid", 32'(out_valid), 32'd0);
         chk("t6_idle_occ",   32'(occupancy), 32'd0);
      end
      drive(7'h53, 26'h0000007, 1'b1);
      step();
      in_valid = 1'b0;
      chk("t6_new_valid", 32'(out_valid), 32'd1);
      chk("t6_new_op",    32'(out_op),    32'h53);
      step();
      out_ready = 1'b0;
      chk("t6_occ_final", 32'(occupancy), 32'd0);

      step();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
